pic_exec_sequencer: RTL and testbench
=====================================

Name: pic_exec_sequencer

Overview:
Four-phase (Q1–Q4) instruction sequencer for the PIC10F200-style datapath.
- Accepts 12-bit instructions over a valid/ready handshake.
- Reads the addressed file register and presents opcode, f and W to the external combinational ALU.
- Writes the ALU result back to W or to the file register, as selected by the d bit.
- Owns the W register. Sits between the program-memory fetch path and the ALU/register file.

Parameters:
- FADDR_W, 5, file-register address width (instr[4:0]).
- DATA_W, 8, data width of W, f and ALU result.
- W_RESET, 8'h00, reset value of W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  12  instruction word.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  sequencer can accept instr this cycle.
- f_addr  out  FADDR_W  file-register address (instr_lat[4:0]).
- f_rdata  in  DATA_W  combinational read data for f_addr.
- f_we  out  1  file-register write strobe.
- f_wdata  out  DATA_W  file-register write data.
- alu_opcode  out  12  opcode to ALU (instr_lat).
- alu_f  out  DATA_W  f operand to ALU (f_lat).
- alu_w  out  DATA_W  W operand to ALU (w_reg).
- alu_r  in  DATA_W  ALU result.
- w_out  out  DATA_W  current W register.
- busy  out  1  high in DECODE/READ/EXEC/WRITE.
- illegal  out  1  sticky unsupported-instruction flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE; w_reg = W_RESET; instr_lat = 12'h000; f_lat = 0; r_lat = 0; illegal = 0.
  - f_we = 0 and instr_ready = 0 while rst is high. Both are combinational outputs gated by !rst.
- States: IDLE -> DECODE(Q1) -> READ(Q2) -> EXEC(Q3) -> WRITE(Q4) -> IDLE or DECODE.
- Handshake:
  - instr_ready = 1 in IDLE and WRITE.
  - Accept on the edge where instr_valid & instr_ready; instr is latched into instr_lat and the next state is DECODE.
  - Accepting in WRITE gives back-to-back execution, 4 cycles per instruction.
  - In IDLE with no valid, stay in IDLE.
- Decode classes (on instr_lat, in DECODE):
  - NOP: 12'h000.
  - CLRW: 12'h040.
  - MOVLW: instr[11:8] = 4'b1100, k = instr[7:0].
  - BYTE: instr[11:10] = 2'b00 and not NOP/CLRW; d = instr[5].
  - Anything else is ILLEGAL: set illegal = 1 (held until reset) and execute as NOP.
- READ: f_addr = instr_lat[4:0]; f_lat <= f_rdata at the end of the cycle (BYTE only; other classes leave f_lat unchanged).
- EXEC: alu_opcode/alu_f/alu_w are stable; r_lat <= alu_r at the end of the cycle (BYTE only).
- WRITE, per class:
  - BYTE, d=1: f_we = 1 for exactly this cycle; f_addr = instr_lat[4:0]; f_wdata = r_lat; W unchanged.
  - BYTE, d=0: w_reg <= r_lat at the end of the cycle; f_we = 0.
  - MOVLW: w_reg <= k.
  - CLRW: w_reg <= 0.
  - NOP/ILLEGAL: no writes.
- Output timing:
  - alu_opcode, alu_f, alu_w and f_addr are driven continuously from the latches. They are meaningful only in READ/EXEC/WRITE.
  - f_we is 0 outside WRITE; f_wdata is held at r_lat.
- Latency: the W update is visible on w_out the cycle after WRITE; the f write happens in WRITE. The instruction following a W-writing instruction sees the new W in its EXEC, so there is no hazard.
- Reset mid-operation: the instruction is aborted with no W or f write, and no f_we glitch (gated by rst). Returns to IDLE.
- Simultaneous accept in WRITE: the current write completes and the new instr_lat loads on the same edge. f_wdata/f_addr for the current write are valid during WRITE only.

Test Plan:
1. Reset with rst high for 3 cycles, instr_valid=1 -> instr_ready=0, f_we=0, w_out=0x00, illegal=0. Release -> instr_ready=1 in IDLE.
2. MOVLW 12'hC05 -> busy for 4 cycles; w_out=0x05 the cycle after WRITE; f_we never asserted.
3. W=0x05, ADDWF 12'h1F0 (d=1, f=0x10), f_rdata=0x03, ALU computes w+f -> exactly one f_we pulse with f_addr=0x10, f_wdata=0x08; w_out stays 0x05.
4. W=0x05, ADDWF 12'h1D0 (d=0), f_rdata=0x03 -> w_out=0x08, no f_we.
5. Back-to-back MOVLW 12'hC0A then ADDWF 12'h1D0 with valid held high, f_rdata=0x01 -> second accept occurs in first WRITE; second EXEC alu_w=0x0A; final w_out=0x0B; 8 cycles total.
6. ILLEGAL 12'hFFF -> illegal=1 sticky, no f_we, W unchanged. Then rst asserted during EXEC of 12'h1F0 -> no f_we, state IDLE, illegal=0.

Source files
------------

// File: rtl/pic_exec_sequencer.sv
// Four-phase (Q1-Q4) instruction sequencer for a PIC10F200-style datapath.
// Takes 12-bit instructions over valid/ready and reads the addressed file register.
// It drives the external combinational ALU and writes the result back to W or to f.
// The W register lives here.
module pic_exec_sequencer #(
   parameter int unsigned          FADDR_W = 5,
   parameter int unsigned          DATA_W  = 8,
   parameter logic [DATA_W-1:0]    W_RESET = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [11:0]         instr,
   input  logic                instr_valid,
   output logic                instr_ready,
   output logic [FADDR_W-1:0]  f_addr,
   input  logic [DATA_W-1:0]   f_rdata,
   output logic                f_we,
   output logic [DATA_W-1:0]   f_wdata,
   output logic [11:0]         alu_opcode,
   output logic [DATA_W-1:0]   alu_f,
   output logic [DATA_W-1:0]   alu_w,
   input  logic [DATA_W-1:0]   alu_r,
   output logic [DATA_W-1:0]   w_out,
   output logic                busy,
   output logic                illegal
);

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StRead,
      StExec,
      StWrite
   } state_e;

   state_e              state_q, state_d;
   logic [11:0]         instr_lat;
   logic [DATA_W-1:0]   f_lat;
   logic [DATA_W-1:0]   r_lat;
   logic [DATA_W-1:0]   w_reg;

   logic is_nop, is_clrw, is_movlw, is_byte, is_illegal, d_bit, accept;
   logic [DATA_W-1:0] lit_k;

   // Instruction class decode from the latched word; stable from DECODE through WRITE.
   always_comb begin
      is_nop     = (instr_lat == 12'h000);
      is_clrw    = (instr_lat == 12'h040);
      is_movlw   = (instr_lat[11:8] == 4'b1100);
      is_byte    = (instr_lat[11:10] == 2'b00) && !is_nop && !is_clrw;
      is_illegal = !(is_nop || is_clrw || is_movlw || is_byte);
      d_bit      = instr_lat[5];
      lit_k      = DATA_W'(instr_lat[7:0]);
   end

   // Handshake and write strobe, forced low while reset is asserted.
   always_comb begin
      instr_ready = !rst && ((state_q == StIdle) || (state_q == StWrite));
      accept      = instr_valid && instr_ready;
      f_we        = !rst && (state_q == StWrite) && is_byte && d_bit;
      busy        = (state_q != StIdle);
      f_addr      = instr_lat[FADDR_W-1:0];
      f_wdata     = r_lat;
      alu_opcode  = instr_lat;
      alu_f       = f_lat;
      alu_w       = w_reg;
      w_out       = w_reg;
   end

   // Next-state logic: fixed Q1..Q4 walk, WRITE may chain straight into a new DECODE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StDecode;
         StDecode: state_d = StRead;
         StRead:   state_d = StExec;
         StExec:   state_d = StWrite;
         StWrite:  state_d = accept ? StDecode : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath latches and W; a W write in WRITE and a new accept share the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_lat <= 12'h000;
         f_lat     <= '0;
         r_lat     <= '0;
         w_reg     <= W_RESET;
         illegal   <= 1'b0;
      end else begin
         if (accept) begin
            instr_lat <= instr;
         end
         if ((state_q == StDecode) && is_illegal) begin
            illegal <= 1'b1;
         end
         if ((state_q == StRead) && is_byte) begin
            f_lat <= f_rdata;
         end
         if ((state_q == StExec) && is_byte) begin
            r_lat <= alu_r;
         end
         if (state_q == StWrite) begin
            if (is_byte && !d_bit) begin
               w_reg <= r_lat;
            end else if (is_movlw) begin
               w_reg <= lit_k;
            end else if (is_clrw) begin
               w_reg <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pic_exec_sequencer.sv
// Directed bench for pic_exec_sequencer; the ALU is modelled as w + f.
module tb_pic_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  f_addr;
   logic [7:0]  f_rdata;
   logic        f_we;
   logic [7:0]  f_wdata;
   logic [11:0] alu_opcode;
   logic [7:0]  alu_f;
   logic [7:0]  alu_w;
   logic [7:0]  alu_r;
   logic [7:0]  w_out;
   logic        busy;
   logic        illegal;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int fwe_seen;
   int busy_seen;

   always #5 clk = ~clk;

   assign alu_r = alu_w + alu_f;

   pic_exec_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .f_addr      (f_addr),
      .f_rdata     (f_rdata),
      .f_we        (f_we),
      .f_wdata     (f_wdata),
      .alu_opcode  (alu_opcode),
      .alu_f       (alu_f),
      .alu_w       (alu_w),
      .alu_r       (alu_r),
      .w_out       (w_out),
      .busy        (busy),
      .illegal     (illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample away from the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
      fwe_seen  += int'(f_we);
      busy_seen += int'(busy);
   endtask

   initial begin
      rst         = 1'b1;
      instr       = 12'hC05;
      instr_valid = 1'b1;
      f_rdata     = 8'h00;
      fwe_seen    = 0;
      busy_seen   = 0;

      // 1. Reset held for 3 cycles with valid high.
      cyc(); cyc(); cyc();
      check("rst_ready", 32'(instr_ready), 32'd0);
      check("rst_fwe", 32'(f_we), 32'd0);
      check("rst_w", 32'(w_out), 32'h00);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      instr_valid = 1'b0;
      #1;
      check("idle_ready", 32'(instr_ready), 32'd1);

      // 2. MOVLW 0x05.
      cyc();
      instr = 12'hC05; instr_valid = 1'b1; fwe_seen = 0; busy_seen = 0;
      cyc();
      instr_valid = 1'b0;
      check("movlw_decode_busy", 32'(busy), 32'd1);
      check("movlw_decode_ready", 32'(instr_ready), 32'd0);
      cyc(); cyc(); cyc();
      check("movlw_write_ready", 32'(instr_ready), 32'd1);
      check("movlw_write_w_old", 32'(w_out), 32'h00);
      cyc();
      check("movlw_w", 32'(w_out), 32'h05);
      check("movlw_busy_cycles", 32'(busy_seen), 32'd4);
      check("movlw_no_fwe", 32'(fwe_seen), 32'd0);

      // 3. ADDWF 0x10,F with f=3.
      instr = 12'h1F0; instr_valid = 1'b1; f_rdata = 8'h03; fwe_seen = 0;
      cyc();
      instr_valid = 1'b0;
      cyc();
      check("addf_read_faddr", 32'(f_addr), 32'h10);
      cyc();
      check("addf_exec_opcode", 32'(alu_opcode), 32'h1F0);
      check("addf_exec_alu_f", 32'(alu_f), 32'h03);
      check("addf_exec_alu_w", 32'(alu_w), 32'h05);
      cyc();
      check("addf_write_fwe", 32'(f_we), 32'd1);
      check("addf_write_faddr", 32'(f_addr), 32'h10);
      check("addf_write_fwdata", 32'(f_wdata), 32'h08);
      cyc();
      check("addf_fwe_pulses", 32'(fwe_seen), 32'd1);
      check("addf_w_kept", 32'(w_out), 32'h05);

      // 4. ADDWF 0x10,W with f=3.
      instr = 12'h1D0; instr_valid = 1'b1; fwe_seen = 0;
      cyc();
      instr_valid = 1'b0;
      cyc(); cyc(); cyc(); cyc();
      check("addw_w", 32'(w_out), 32'h08);
      check("addw_no_fwe", 32'(fwe_seen), 32'd0);

      // 5. Back-to-back MOVLW 0x0A then ADDWF 0x10,W with f=1.
      instr = 12'hC0A; instr_valid = 1'b1; f_rdata = 8'h01; fwe_seen = 0; busy_seen = 0;
      cyc();
      instr = 12'h1D0;
      cyc(); cyc(); cyc();
      check("b2b_write_ready", 32'(instr_ready), 32'd1);
      cyc();
      instr_valid = 1'b0;
      check("b2b_second_decode_busy", 32'(busy), 32'd1);
      check("b2b_w_after_movlw", 32'(w_out), 32'h0A);
      check("b2b_second_opcode", 32'(alu_opcode), 32'h1D0);
      cyc(); cyc();
      check("b2b_exec_alu_w", 32'(alu_w), 32'h0A);
      check("b2b_exec_alu_f", 32'(alu_f), 32'h01);
      cyc(); cyc();
      check("b2b_w", 32'(w_out), 32'h0B);
      check("b2b_busy_cycles", 32'(busy_seen), 32'd8);
      check("b2b_idle", 32'(busy), 32'd0);
      check("b2b_no_fwe", 32'(fwe_seen), 32'd0);

      // 6. Illegal opcode, then reset during EXEC of an f-writing instruction.
      instr = 12'hFFF; instr_valid = 1'b1; fwe_seen = 0;
      cyc();
      instr_valid = 1'b0;
      check("ill_decode_flag_clear", 32'(illegal), 32'd0);
      cyc();
      check("ill_read_flag", 32'(illegal), 32'd1);
      cyc(); cyc(); cyc();
      check("ill_sticky", 32'(illegal), 32'd1);
      check("ill_w_kept", 32'(w_out), 32'h0B);
      check("ill_no_fwe", 32'(fwe_seen), 32'd0);

      instr = 12'h1F0; instr_valid = 1'b1; f_rdata = 8'h03;
      cyc();
      instr_valid = 1'b0;
      cyc(); cyc();
      check("abort_in_exec", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_illegal", 32'(illegal), 32'd0);
      check("abort_fwe", 32'(f_we), 32'd0);
      check("abort_ready", 32'(instr_ready), 32'd0);
      check("abort_w", 32'(w_out), 32'h00);
      cyc(); cyc();
      check("abort_no_fwe", 32'(fwe_seen), 32'd0);
      rst = 1'b0;
      #1;
      check("abort_idle_ready", 32'(instr_ready), 32'd1);
      cyc();
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_fwe_after", 32'(fwe_seen), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
